// File: rtl/timetag_tx.sv
// timetag_tx: turns each timer period tick into an 8-byte time-tag frame
// (header, six period bytes MSB first, XOR checksum) on a byte-wide
// valid/ready stream. One pending frame absorbs back-pressure; ticks that
// find both the active frame and the pending slot occupied are counted.
module timetag_tx #(
    parameter logic [7:0]  HEADER   = 8'hBC,
    parameter int unsigned PERIOD_W = 48
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                period_done,
    input  logic [PERIOD_W-1:0] period,
    output logic [7:0]          tx_data,
    output logic                tx_k,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic                busy,
    output logic [7:0]          missed
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_CSUM
    } state_t;

    state_t        state, state_n;
    logic [2:0]    idx, idx_n;
    logic [47:0]   frame, frame_n;
    logic [47:0]   pend, pend_n;
    logic          pend_v, pend_v_n;
    logic [7:0]    csum, csum_n;
    logic [7:0]    missed_n;
    logic [7:0]    tx_data_n;
    logic          tx_k_n;
    logic          xfer;
    logic          last;

    // Byte i of the frame, i = 0 selects the most significant byte.
    function automatic logic [7:0] byte_sel(input logic [47:0] f, input logic [2:0] i);
        case (i)
            3'd0:    byte_sel = f[47:40];
            3'd1:    byte_sel = f[39:32];
            3'd2:    byte_sel = f[31:24];
            3'd3:    byte_sel = f[23:16];
            3'd4:    byte_sel = f[15:8];
            default: byte_sel = f[7:0];
        endcase
    endfunction

    // tx_valid mirrors state != IDLE, so it doubles as the handshake qualifier.
    assign xfer = tx_valid & tx_ready;

    // Next-state, storage and next-output computation.
    always_comb begin
        state_n  = state;
        idx_n    = idx;
        frame_n  = frame;
        pend_n   = pend;
        pend_v_n = pend_v;
        csum_n   = csum;
        missed_n = missed;
        last     = 1'b0;

        case (state)
            S_IDLE: begin
                if (period_done) begin
                    frame_n = period;
                    csum_n  = '0;
                    state_n = S_HDR;
                end
            end
            S_HDR: begin
                if (xfer) begin
                    idx_n   = '0;
                    state_n = S_DATA;
                end
            end
            S_DATA: begin
                if (xfer) begin
                    csum_n = csum ^ byte_sel(frame, idx);
                    if (idx == 3'd5) begin
                        idx_n   = '0;
                        state_n = S_CSUM;
                    end else begin
                        idx_n = idx + 3'd1;
                    end
                end
            end
            S_CSUM: begin
                if (xfer) begin
                    last = 1'b1;
                    if (pend_v) begin
                        // Pending frame starts immediately; a tick on this
                        // same edge refills the pending slot.
                        frame_n  = pend;
                        pend_v_n = period_done;
                        if (period_done) begin
                            pend_n = period;
                        end
                        csum_n  = '0;
                        state_n = S_HDR;
                    end else if (period_done) begin
                        frame_n = period;
                        csum_n  = '0;
                        state_n = S_HDR;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase

        // Ticks arriving mid-frame (the CSUM transfer edge is handled above).
        if ((state != S_IDLE) && period_done && !last) begin
            if (!pend_v) begin
                pend_n   = period;
                pend_v_n = 1'b1;
            end else if (missed != '1) begin
                missed_n = missed + 8'd1;
            end
        end

        // Registered outputs are derived from the state being entered.
        tx_data_n = '0;
        tx_k_n    = 1'b0;
        case (state_n)
            S_HDR: begin
                tx_data_n = HEADER;
                tx_k_n    = 1'b1;
            end
            S_DATA:  tx_data_n = byte_sel(frame_n, idx_n);
            S_CSUM:  tx_data_n = csum_n;
            default: tx_data_n = '0;
        endcase
    end

    // State, storage and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            idx      <= '0;
            frame    <= '0;
            pend     <= '0;
            pend_v   <= 1'b0;
            csum     <= '0;
            missed   <= '0;
            tx_data  <= '0;
            tx_k     <= 1'b0;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            frame    <= frame_n;
            pend     <= pend_n;
            pend_v   <= pend_v_n;
            csum     <= csum_n;
            missed   <= missed_n;
            tx_data  <= tx_data_n;
            tx_k     <= tx_k_n;
            tx_valid <= (state_n != S_IDLE);
            busy     <= (state_n != S_IDLE);
        end
    end

endmodule

// File: tb/tb_timetag_tx.sv
// tb_timetag_tx: randomized scoreboard bench. A frame-level model decides
// which ticks become frames and pushes their bytes into a queue; a monitor
// pops and compares on every handshake and checks status outputs.
module tb_timetag_tx;

    logic        clk;
    logic        rst;
    logic        period_done;
    logic [47:0] period;
    logic [7:0]  tx_data;
    logic        tx_k;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic [7:0]  missed;

    timetag_tx #(.HEADER(8'hBC), .PERIOD_W(48)) dut (
        .clk         (clk),
        .rst         (rst),
        .period_done (period_done),
        .period      (period),
        .tx_data     (tx_data),
        .tx_k        (tx_k),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .missed      (missed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Reference model state: bytes left in the current frame (0 = idle),
    // whether a second frame is queued, and the drop counter.
    logic [8:0]  exp_q[$];
    int          m_left;
    bit          m_pend_v;
    int          m_missed;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void push_frame(input logic [47:0] p);
        logic [7:0] cs;
        logic [7:0] b;
        cs = 8'h00;
        exp_q.push_back({1'b1, 8'hBC});
        for (int i = 0; i < 6; i++) begin
            b = 8'((p >> (40 - 8 * i)) & 48'hFF);
            cs = cs ^ b;
            exp_q.push_back({1'b0, b});
        end
        exp_q.push_back({1'b0, cs});
    endfunction

    // Frame-level model, advanced on each clock edge from the sampled inputs.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_q.delete();
            m_left   = 0;
            m_pend_v = 1'b0;
            m_missed = 0;
        end else if (m_left == 0) begin
            if (period_done) begin
                push_frame(period);
                m_left = 8;
            end
        end else begin
            bit done;
            done = tx_ready && (m_left == 1);
            if (tx_ready) m_left = m_left - 1;
            if (done) begin
                if (m_pend_v) begin
                    m_left   = 8;
                    m_pend_v = period_done;
                    if (period_done) push_frame(period);
                end else if (period_done) begin
                    push_frame(period);
                    m_left = 8;
                end
            end else if (period_done) begin
                if (!m_pend_v) begin
                    m_pend_v = 1'b1;
                    push_frame(period);
                end else if (m_missed < 255) begin
                    m_missed = m_missed + 1;
                end
            end
        end
    end

    // Monitor: compares on the falling edge, away from the active edge.
    bit         prev_stall;
    logic [8:0] prev_byte;
    always @(negedge clk) begin
        if (!rst) begin
            prev_stall = 1'b0;
        end else begin
            chk("tx_valid", 16'(tx_valid), 16'(m_left > 0));
            chk("busy", 16'(busy), 16'(m_left > 0));
            chk("missed", 16'(missed), 16'(m_missed));
            if (prev_stall && tx_valid)
                chk("stall_hold", 16'({tx_k, tx_data}), 16'(prev_byte));
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_byte", 16'({tx_k, tx_data}), 16'h1FF);
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    chk("byte", 16'({tx_k, tx_data}), 16'(e));
                end
            end
            prev_stall = tx_valid && !tx_ready;
            prev_byte  = {tx_k, tx_data};
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input logic [47:0] p);
        period_done = 1'b1;
        period      = p;
        step();
        period_done = 1'b0;
    endtask

    function automatic logic [47:0] rnd48();
        return {16'($urandom()), $urandom()};
    endfunction

    // Run until the model and the queue are empty; rnd_ready stalls randomly.
    task automatic drain(input bit rnd_ready);
        int i;
        period_done = 1'b0;
        i = 0;
        while (!(m_left == 0 && exp_q.size() == 0) && i < 2000) begin
            tx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
            i++;
        end
        tx_ready = 1'b1;
        chk("drain_timeout", 16'(i < 2000), 16'd1);
        step();
        chk("idle_valid", 16'(tx_valid), 16'd0);
        chk("idle_busy", 16'(busy), 16'd0);
    endtask

    task automatic wait_left(input int n);
        int i;
        i = 0;
        while (m_left != n && i < 200) begin
            step();
            i++;
        end
        chk("wait_timeout", 16'(i < 200), 16'd1);
    endtask

    initial begin
        int snap;
        rst         = 1'b0;
        period_done = 1'b0;
        period      = '0;
        tx_ready    = 1'b1;
        step();
        step();
        chk("rst_valid", 16'(tx_valid), 16'd0);
        chk("rst_data", 16'({tx_k, tx_data}), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_missed", 16'(missed), 16'd0);
        rst = 1'b1;
        step();

        // Directed single frame, then the same frame under random stalls.
        tick(48'h0123_4567_89AB);
        drain(1'b0);
        tx_ready = 1'($urandom_range(0, 1));
        tick(48'h0123_4567_89AB);
        drain(1'b1);

        // Stalled: ticks 1,2,3 -> tick 3 dropped, then frames 1 and 2 back to back.
        tx_ready = 1'b0;
        tick(48'd1);
        step();
        tick(48'd2);
        step();
        tick(48'd3);
        step();
        chk("missed_one", 16'(missed), 16'd1);
        drain(1'b0);

        // Tick on the exact CSUM transfer edge while a frame is pending.
        snap = m_missed;
        tx_ready = 1'b1;
        tick(rnd48());
        tick(rnd48());
        wait_left(1);
        tick(rnd48());
        chk("csum_edge_missed", 16'(missed), 16'(snap));
        drain(1'b0);
        chk("csum_edge_missed_after", 16'(missed), 16'(snap));

        // Saturation: 302 ticks under a stall leave 300 dropped.
        tx_ready = 1'b0;
        for (int i = 0; i < 302; i++) tick(rnd48());
        step();
        chk("missed_sat", 16'(missed), 16'd255);
        drain(1'b0);

        // Asynchronous reset mid-frame during D2.
        tx_ready = 1'b1;
        tick(rnd48());
        wait_left(5);
        #3;
        rst = 1'b0;
        #1;
        chk("arst_valid", 16'(tx_valid), 16'd0);
        chk("arst_busy", 16'(busy), 16'd0);
        chk("arst_missed", 16'(missed), 16'd0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        step();
        tick(rnd48());
        chk("post_rst_hdr", 16'({tx_valid, tx_k, tx_data}), 16'h3BC);
        drain(1'b0);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            tx_ready    = ($urandom_range(0, 3) != 0);
            period_done = ($urandom_range(0, 11) == 0);
            period      = rnd48();
            step();
        end
        drain(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
